// File: rtl/i2c_pkg.sv
// i2c_pkg
//   Shared definitions for the single-byte I2C master: the phase encoding seen by
//   both the control FSM and the i2c_datapath, plus small decode helpers.
//   No ports.
package i2c_pkg;

    // Phase encoding carried on the 8-bit state bus to the datapath.
    typedef enum logic [7:0] {
        IDLE       = 8'd0,
        START      = 8'd1,
        ADDRESS    = 8'd2,
        READ_ACK   = 8'd3,
        WRITE_DATA = 8'd4,
        READ_ACK2  = 8'd5,
        READ_DATA  = 8'd6,
        WRITE_ACK2 = 8'd7,
        STOP       = 8'd8
    } i2c_state_t;

    localparam logic [3:0] BIT_MSB = 4'd7;

    // SCL toggles only while bits or ACKs are being clocked.
    function automatic logic scl_active(input i2c_state_t s);
        return s inside {ADDRESS, READ_ACK, WRITE_DATA, READ_ACK2, READ_DATA, WRITE_ACK2};
    endfunction

    // SDA is released whenever the slave owns the line.
    function automatic logic sda_driven(input i2c_state_t s);
        return !(s inside {READ_ACK, READ_ACK2, READ_DATA});
    endfunction

endpackage

// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen
//   Free-running SCL timebase. A divider counts 0..DIV_HALF-1; each wrap toggles
//   the SCL phase. The wrap that takes the phase low is a fall tick, the one that
//   takes it high is a rise tick. scl_negedge is the fall tick delayed one clock.
// Ports
//   i_clk           system clock
//   i_rst           asynchronous active-high reset
//   i_scl_en        1 = drive SCL from the phase, 0 = hold SCL high
//   o_scl           SCL line level
//   o_scl_negedge   one-clock pulse, high the clock after a fall tick
//   o_rise_tick     combinational strobe on the clock edge where SCL rises
module i2c_scl_gen #(
    parameter int DIV_HALF = 250
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl_en,
    output logic o_scl,
    output logic o_scl_negedge,
    output logic o_rise_tick
);

    localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

    logic [DW-1:0] r_div;
    logic          r_ph;
    logic          r_negedge;
    logic          w_wrap;

    assign w_wrap = (r_div == DW'(DIV_HALF - 1));

    // Phase resets high so the line idles high and the first wrap is a fall.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div     <= '0;
            r_ph      <= 1'b1;
            r_negedge <= 1'b0;
        end else begin
            r_div     <= w_wrap ? '0 : r_div + DW'(1);
            if (w_wrap) begin
                r_ph <= ~r_ph;
            end
            r_negedge <= w_wrap & r_ph;
        end
    end

    assign o_rise_tick   = w_wrap & ~r_ph;
    assign o_scl_negedge = r_negedge;
    assign o_scl         = i_scl_en ? r_ph : 1'b1;

endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl
//   Control FSM for the single-byte I2C master. Accepts a host request, sequences
//   state/count/rw for the i2c_datapath, samples slave ACKs and reports status.
//   State and count change on the clock where scl_negedge falls, so they are
//   settled well before the datapath's next scl_negedge rising edge.
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   start_req, rw_req   host request pulse and direction (1 = read)
//   SDA_in              synchronised SDA level for ACK sampling
//   state, count, rw    phase, bit index (7..0) and latched direction to datapath
//   scl_negedge         datapath clock pulse
//   i2c_scl_en          1 = SCL toggling
//   i2c_write_en        1 = master drives SDA
//   SCL                 I2C clock line
//   busy, done, ack_err host status
//
// state      | meaning
// IDLE       | waiting for an accepted request
// START      | start condition, SCL held high
// ADDRESS    | shifting address + R/W bits, count 7..0
// READ_ACK   | slave acknowledges address
// WRITE_DATA | shifting write byte, count 7..0
// READ_ACK2  | slave acknowledges write byte
// READ_DATA  | slave shifts read byte, count 7..0
// WRITE_ACK2 | master acknowledges read byte
// STOP       | stop condition, then back to IDLE with a done pulse
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int DIV_HALF = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_req,
    input  logic       rw_req,
    input  logic       SDA_in,
    output logic [7:0] state,
    output logic [3:0] count,
    output logic       rw,
    output logic       scl_negedge,
    output logic       i2c_scl_en,
    output logic       i2c_write_en,
    output logic       SCL,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    i2c_state_t r_state, w_state_nxt;
    logic [3:0] r_count, w_count_nxt;
    logic       r_rw, w_rw_nxt;
    logic       r_pending, w_pending_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_done, w_done_nxt;
    logic       r_ack_err, w_ack_err_nxt;
    logic       r_ack_bit, w_ack_bit_nxt;
    logic       w_scl_negedge;
    logic       w_rise_tick;
    logic       w_update;
    logic       w_scl_en;

    assign w_scl_en = scl_active(r_state);

    i2c_scl_gen #(
        .DIV_HALF(DIV_HALF)
    ) u_scl_gen (
        .i_clk         (clk),
        .i_rst         (reset),
        .i_scl_en      (w_scl_en),
        .o_scl         (SCL),
        .o_scl_negedge (w_scl_negedge),
        .o_rise_tick   (w_rise_tick)
    );

    // The FSM steps on the edge that ends the scl_negedge pulse.
    assign w_update = w_scl_negedge;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= BIT_MSB;
            r_rw      <= 1'b0;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_ack_bit <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_rw      <= w_rw_nxt;
            r_pending <= w_pending_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_ack_err <= w_ack_err_nxt;
            r_ack_bit <= w_ack_bit_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_rw_nxt      = r_rw;
        w_pending_nxt = r_pending;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_ack_err_nxt = r_ack_err;
        w_ack_bit_nxt = r_ack_bit;

        // ACK is taken while SCL rises; it steers the following update.
        if (w_rise_tick && (r_state == READ_ACK || r_state == READ_ACK2)) begin
            w_ack_bit_nxt = SDA_in;
        end

        // Requests while busy are dropped, not queued.
        if (start_req && !r_busy) begin
            w_rw_nxt      = rw_req;
            w_pending_nxt = 1'b1;
            w_busy_nxt    = 1'b1;
            w_ack_err_nxt = 1'b0;
        end

        if (w_update) begin
            case (r_state)
                IDLE: begin
                    if (r_pending) begin
                        w_state_nxt   = START;
                        w_pending_nxt = 1'b0;
                    end
                end
                START: begin
                    w_state_nxt = ADDRESS;
                    w_count_nxt = BIT_MSB;
                end
                ADDRESS: begin
                    if (r_count == 4'd0) begin
                        w_state_nxt = READ_ACK;
                        w_count_nxt = BIT_MSB;
                    end else begin
                        w_count_nxt = r_count - 4'd1;
                    end
                end
                READ_ACK: begin
                    w_count_nxt = BIT_MSB;
                    if (!r_ack_bit) begin
                        w_state_nxt = r_rw ? READ_DATA : WRITE_DATA;
                    end else begin
                        w_state_nxt   = STOP;
                        w_ack_err_nxt = 1'b1;
                    end
                end
                WRITE_DATA: begin
                    if (r_count == 4'd0) begin
                        w_state_nxt = READ_ACK2;
                        w_count_nxt = BIT_MSB;
                    end else begin
                        w_count_nxt = r_count - 4'd1;
                    end
                end
                READ_ACK2: begin
                    w_state_nxt = STOP;
                    if (r_ack_bit) begin
                        w_ack_err_nxt = 1'b1;
                    end
                end
                READ_DATA: begin
                    if (r_count == 4'd0) begin
                        w_state_nxt = WRITE_ACK2;
                        w_count_nxt = BIT_MSB;
                    end else begin
                        w_count_nxt = r_count - 4'd1;
                    end
                end
                WRITE_ACK2: begin
                    w_state_nxt = STOP;
                end
                STOP: begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_count_nxt = BIT_MSB;
                end
            endcase
        end
    end

    assign state        = r_state;
    assign count        = r_count;
    assign rw           = r_rw;
    assign scl_negedge  = w_scl_negedge;
    assign i2c_scl_en   = w_scl_en;
    assign i2c_write_en = sda_driven(r_state);
    assign busy         = r_busy;
    assign done         = r_done;
    assign ack_err      = r_ack_err;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl
//   Self-checking bench for i2c_master_ctrl with DIV_HALF=4. A transaction-level
//   model predicts the phase sequence as a queue of (state, count, error) steps
//   and derives SCL timing from the clock count since reset release.
module tb_i2c_master_ctrl;
    import i2c_pkg::*;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_req = 1'b0;
    logic       rw_req = 1'b0;
    logic       SDA_in = 1'b1;
    logic [7:0] state;
    logic [3:0] count;
    logic       rw, scl_negedge, i2c_scl_en, i2c_write_en, SCL, busy, done, ack_err;

    int errors = 0;
    int checks = 0;
    int sda_mode = 0;   // 0 random, 1 ACK (low), 2 NACK (high)

    i2c_master_ctrl #(.DIV_HALF(D)) dut (
        .clk(clk), .reset(reset), .start_req(start_req), .rw_req(rw_req), .SDA_in(SDA_in),
        .state(state), .count(count), .rw(rw), .scl_negedge(scl_negedge),
        .i2c_scl_en(i2c_scl_en), .i2c_write_en(i2c_write_en), .SCL(SCL),
        .busy(busy), .done(done), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [7:0] st; logic [3:0] cnt; logic err; } step_t;
    step_t q[$];
    int unsigned k = 0;
    logic [7:0] m_state = IDLE;
    logic [3:0] m_count = 4'd7;
    logic m_rw = 0, m_pending = 0, m_busy = 0, m_done = 0, m_ack_err = 0, m_neg = 0, m_ph = 1;

    function automatic void push(input logic [7:0] s, input logic [3:0] c, input logic e);
        step_t t;
        t.st = s; t.cnt = c; t.err = e;
        q.push_back(t);
    endfunction

    function automatic void push_bits(input logic [7:0] s);
        for (int i = 7; i >= 0; i--) push(s, 4'(i), 1'b0);
    endfunction

    initial forever begin : model
        bit upd, rise, fall, acc;
        step_t t;
        @(posedge clk or posedge reset);
        if (reset) begin
            k = 0; q.delete();
            m_state = IDLE; m_count = 4'd7; m_rw = 0; m_pending = 0; m_busy = 0;
            m_done = 0; m_ack_err = 0; m_neg = 0; m_ph = 1;
        end else begin
            k++;
            fall = (k % (2 * D)) == D;
            rise = (k % (2 * D)) == 0;
            upd  = (k % (2 * D)) == D + 1;
            acc  = start_req && !m_busy;
            m_done = 0;
            if (rise && m_state == READ_ACK) begin
                if (SDA_in == 1'b0) begin
                    push_bits(m_rw ? READ_DATA : WRITE_DATA);
                    if (m_rw) begin
                        push(WRITE_ACK2, 4'd7, 1'b0); push(STOP, 4'd7, 1'b0); push(IDLE, 4'd7, 1'b0);
                    end else begin
                        push(READ_ACK2, 4'd7, 1'b0);
                    end
                end else begin
                    push(STOP, 4'd7, 1'b1); push(IDLE, 4'd7, 1'b0);
                end
            end
            if (rise && m_state == READ_ACK2) begin
                push(STOP, 4'd7, SDA_in); push(IDLE, 4'd7, 1'b0);
            end
            if (upd && (m_state != IDLE || m_pending) && q.size() > 0) begin
                t = q.pop_front();
                if (m_state == IDLE) m_pending = 0;
                if (m_state == STOP) begin m_done = 1; m_busy = 0; end
                if (t.err) m_ack_err = 1;
                m_state = t.st;
                m_count = t.cnt;
            end
            if (acc) begin
                m_rw = rw_req; m_pending = 1; m_busy = 1; m_ack_err = 0;
                q.delete();
                push(START, 4'd7, 1'b0); push_bits(ADDRESS); push(READ_ACK, 4'd7, 1'b0);
            end
            m_neg = fall;
            m_ph  = ((k / D) % 2) == 0;
        end
    end

    // ---------------- SDA driver ----------------
    initial forever begin : sda_drv
        @(negedge clk);
        case (sda_mode)
            0:       SDA_in = 1'($urandom_range(0, 1));
            1:       SDA_in = 1'b0;
            default: SDA_in = 1'b1;
        endcase
    end

    // ---------------- per-cycle compare + monitors ----------------
    int clr_gen = 0;
    int st_cycles[9];
    int done_cnt, rd_we_cnt, wa2_we_cnt, per_min, per_max, neg_run, neg_run_max, unstable;

    initial forever begin : chk
        logic en_e, we_e;
        int seen_gen, cyc, last_rise;
        logic prev_scl, prev_neg;
        logic [7:0] prev_state;
        @(negedge clk);
        if (!reset) begin
            en_e = m_state inside {ADDRESS, READ_ACK, WRITE_DATA, READ_ACK2, READ_DATA, WRITE_ACK2};
            we_e = !(m_state inside {READ_ACK, READ_ACK2, READ_DATA});
            check("state", state, m_state);
            check("count", count, m_count);
            check("rw", rw, m_rw);
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("ack_err", ack_err, m_ack_err);
            check("scl_negedge", scl_negedge, m_neg);
            check("i2c_scl_en", i2c_scl_en, en_e);
            check("i2c_write_en", i2c_write_en, we_e);
            check("SCL", SCL, en_e ? m_ph : 1'b1);

            cyc++;
            if (clr_gen != seen_gen) begin
                seen_gen = clr_gen;
                foreach (st_cycles[i]) st_cycles[i] = 0;
                done_cnt = 0; rd_we_cnt = 0; wa2_we_cnt = 0;
                per_min = 1000; per_max = 0; neg_run_max = 0; unstable = 0; last_rise = -1;
            end
            if (state < 8'd9) st_cycles[state]++;
            done_cnt += int'(done);
            if (state == READ_DATA && i2c_write_en) rd_we_cnt++;
            if (state == WRITE_ACK2 && i2c_write_en) wa2_we_cnt++;
            if (state != ADDRESS) last_rise = -1;
            else if (SCL && !prev_scl) begin
                if (last_rise >= 0) begin
                    if (cyc - last_rise < per_min) per_min = cyc - last_rise;
                    if (cyc - last_rise > per_max) per_max = cyc - last_rise;
                end
                last_rise = cyc;
            end
            neg_run = scl_negedge ? neg_run + 1 : 0;
            if (neg_run > neg_run_max) neg_run_max = neg_run;
            if (scl_negedge && !prev_neg && state != prev_state) unstable++;
            prev_scl = SCL; prev_neg = scl_negedge; prev_state = state;
        end
    end

    // ---------------- stimulus ----------------
    task automatic launch(input logic r, input int mode);
        int n = 0;
        while (busy && n < 2000) begin @(negedge clk); n++; end
        check("launch_wait", n < 2000, 1);
        sda_mode = mode;
        rw_req = r;
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        rw_req = 1'($urandom_range(0, 1));
        clr_gen++;
    endtask

    // Waits for done, throwing ignored requests at the busy controller.
    task automatic wait_done();
        int n = 0;
        while (!done && n < 2000) begin
            start_req = ($urandom_range(0, 15) == 0);
            rw_req = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        start_req = 1'b0;
        check("done_timeout", n < 2000, 1);
        #1;
    endtask

    initial begin : stim
        int n;
        repeat (3) @(negedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_count", count, 7);
        check("rst_rw", rw, 0);
        check("rst_scl_negedge", scl_negedge, 0);
        check("rst_scl_en", i2c_scl_en, 0);
        check("rst_write_en", i2c_write_en, 1);
        check("rst_SCL", SCL, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // write with ACKs
        launch(1'b0, 1);
        wait_done();
        check("wr_done_pulses", done_cnt, 1);
        check("wr_start_cycles", st_cycles[START], 8);
        check("wr_addr_cycles", st_cycles[ADDRESS], 64);
        check("wr_rack_cycles", st_cycles[READ_ACK], 8);
        check("wr_data_cycles", st_cycles[WRITE_DATA], 64);
        check("wr_rack2_cycles", st_cycles[READ_ACK2], 8);
        check("wr_stop_cycles", st_cycles[STOP], 8);
        check("wr_ack_err", ack_err, 0);
        check("scl_period_min", per_min, 8);
        check("scl_period_max", per_max, 8);
        check("negedge_width", neg_run_max, 1);
        check("state_unstable", unstable, 0);

        // read with ACK
        launch(1'b1, 1);
        wait_done();
        check("rd_data_cycles", st_cycles[READ_DATA], 64);
        check("rd_write_en_in_data", rd_we_cnt, 0);
        check("rd_wack2_cycles", st_cycles[WRITE_ACK2], 8);
        check("rd_write_en_in_wack2", wa2_we_cnt, 8);
        check("rd_rw", rw, 1);
        check("rd_ack_err", ack_err, 0);

        // address NACK
        launch(1'b0, 2);
        wait_done();
        check("nack_ack_err", ack_err, 1);
        check("nack_done_pulses", done_cnt, 1);
        check("nack_no_wdata", st_cycles[WRITE_DATA], 0);
        check("nack_no_rdata", st_cycles[READ_DATA], 0);

        // request in the done cycle is accepted and clears ack_err
        sda_mode = 1;
        rw_req = 1'b1;
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        #1;
        check("donecyc_busy", busy, 1);
        check("donecyc_ack_err", ack_err, 0);
        check("donecyc_rw", rw, 1);
        wait_done();
        check("ignored_rw_kept", rw, 1);

        // randomized traffic
        for (int t = 0; t < 30; t++) begin
            launch(1'($urandom_range(0, 1)), 0);
            wait_done();
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end

        // reset in WRITE_DATA with count 3
        launch(1'b0, 1);
        n = 0;
        while (!(state == WRITE_DATA && count == 4'd3) && n < 2000) begin @(negedge clk); n++; end
        check("reach_wdata3", n < 2000, 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_state", state, 0);
        check("midrst_SCL", SCL, 1);
        check("midrst_busy", busy, 0);
        check("midrst_write_en", i2c_write_en, 1);
        check("midrst_count", count, 7);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        launch(1'b1, 1);
        wait_done();
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
